l1_l2_interface: RTL and testbench

Core-side bridge between the L1 load-miss queues and the shared L2 bus. Each cycle it takes at most one pending miss from the instruction or data cache miss queue, holds it in a one-entry output register until the L2 accepts it, and routes L2 responses for this core back. Routed responses go out as a miss-queue wake (entry index) plus a registered cache-line fill.

---
 rtl/l1_l2_interface_pkg.sv | 26 ++
 rtl/l1_l2_interface_arbiter.sv | 53 +++++
 rtl/l1_l2_interface.sv | 163 ++++++++++++++++
 tb/tb_l1_l2_interface.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_l2_interface_pkg.sv
// l1_l2_interface_pkg
// Shared types for the L1 <-> L2 bridge: scalar and line widths, miss-queue
// entry index, core identifier and the L2 request type enumeration.
package l1_l2_interface_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int CORE_ID_WIDTH    = 4;
  localparam int CACHE_LINE_BITS  = 512;

  typedef logic [31:0]                           scalar_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0]   l1_miss_entry_idx_t;
  typedef logic [CORE_ID_WIDTH-1:0]              core_id_t;
  typedef logic [CACHE_LINE_BITS-1:0]            cache_line_data_t;

  typedef enum logic [1:0] {
    L2_REQ_LOAD      = 2'd0,
    L2_REQ_LOAD_SYNC = 2'd1,
    L2_REQ_IFETCH    = 2'd2
  } l2_req_type_t;

  // Data-cache misses become load-linked requests when synchronized.
  function automatic l2_req_type_t dcache_req_type(input logic synchronized);
    return synchronized ? L2_REQ_LOAD_SYNC : L2_REQ_LOAD;
  endfunction

endpackage

// File: rtl/l1_l2_interface_arbiter.sv
// l1_l2_interface_arbiter
// Round-robin arbiter. Grants the first requester at or after the priority
// pointer. The pointer only advances past the winner when update_lru is set
// and more than one requester was competing, so a lone requester never
// disturbs the fairness order.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (pointer -> entry 0)
//   request      one bit per requester
//   update_lru   the current grant is being consumed this cycle
//   grant_oh     one-hot grant (zero when nothing requests)
module l1_l2_interface_arbiter #(
  parameter int NUM_ENTRIES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   update_lru,
  output logic [NUM_ENTRIES-1:0] grant_oh
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] winner;
  logic             found;

  always_comb begin
    grant_oh = '0;
    winner   = prio_q;
    found    = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      int cand;
      cand = (int'(prio_q) + i) % NUM_ENTRIES;
      if (!found && request[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
    if (found) grant_oh[winner] = 1'b1;

    prio_d = prio_q;
    if (update_lru && found && ($countones(request) > 1)) begin
      if (int'(winner) == NUM_ENTRIES - 1) prio_d = '0;
      else                                 prio_d = winner + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/l1_l2_interface.sv
// l1_l2_interface
// Core-side bridge between the L1 miss queues and the shared L2 bus.
// Request side: round-robin pick between the data and instruction miss
// queues into a one-entry request register that holds until L2 accepts it.
// Response side: responses tagged with this core are registered and
// delivered one cycle later as a wake pulse plus the fill line.
// Ports:
//   clk, reset                        clock, async active-high reset
//   dcache_miss_*                     data miss queue (ready/ack handshake)
//   icache_miss_*                     instruction miss queue
//   l2_request_*                      request to L2 (valid/ready)
//   l2_response_*                     response broadcast from L2
//   dcache/icache_response_valid      one-cycle wake pulse
//   response_idx, fill_address/data   entry to wake and line to fill
module l1_l2_interface
  import l1_l2_interface_pkg::*;
#(
  parameter core_id_t CORE_ID = '0
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               dcache_miss_ready,
  output logic               dcache_miss_ack,
  input  scalar_t            dcache_miss_addr,
  input  l1_miss_entry_idx_t dcache_miss_idx,
  input  logic               dcache_miss_synchronized,

  input  logic               icache_miss_ready,
  output logic               icache_miss_ack,
  input  scalar_t            icache_miss_addr,
  input  l1_miss_entry_idx_t icache_miss_idx,

  output logic               l2_request_valid,
  input  logic               l2_request_ready,
  output core_id_t           l2_request_core,
  output l1_miss_entry_idx_t l2_request_id,
  output l2_req_type_t       l2_request_type,
  output scalar_t            l2_request_address,

  input  logic               l2_response_valid,
  input  core_id_t           l2_response_core,
  input  l1_miss_entry_idx_t l2_response_id,
  input  logic               l2_response_cache,
  input  scalar_t            l2_response_address,
  input  cache_line_data_t   l2_response_data,

  output logic               dcache_response_valid,
  output logic               icache_response_valid,
  output l1_miss_entry_idx_t response_idx,
  output scalar_t            fill_address,
  output cache_line_data_t   fill_data
);

  // Request register
  logic               req_valid_q, req_valid_d;
  l1_miss_entry_idx_t req_id_q, req_id_d;
  l2_req_type_t       req_type_q, req_type_d;
  scalar_t            req_addr_q, req_addr_d;

  // Staged response
  logic               resp_valid_q, resp_valid_d;
  logic               resp_cache_q, resp_cache_d;
  l1_miss_entry_idx_t resp_idx_q, resp_idx_d;
  scalar_t            resp_addr_q, resp_addr_d;
  cache_line_data_t   resp_data_q, resp_data_d;

  logic       req_free;
  logic       grant_taken;
  logic [1:0] grant_oh;
  logic       resp_hit;

  // The register can take a new entry when empty or when its occupant leaves
  // this cycle. A stray ready while empty is harmless since empty is free.
  assign req_free    = !req_valid_q || l2_request_ready;
  // Acks are gated by reset because the miss queues are being cleared too.
  assign grant_taken = req_free && !reset && (dcache_miss_ready || icache_miss_ready);

  l1_l2_interface_arbiter #(
    .NUM_ENTRIES(2)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   ({icache_miss_ready, dcache_miss_ready}),
    .update_lru(grant_taken),
    .grant_oh  (grant_oh)
  );

  assign dcache_miss_ack = grant_taken && grant_oh[0];
  assign icache_miss_ack = grant_taken && grant_oh[1];

  always_comb begin
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_type_d  = req_type_q;
    req_addr_d  = req_addr_q;
    if (req_free) req_valid_d = 1'b0;
    if (dcache_miss_ack) begin
      req_valid_d = 1'b1;
      req_id_d    = dcache_miss_idx;
      req_type_d  = dcache_req_type(dcache_miss_synchronized);
      req_addr_d  = dcache_miss_addr;
    end else if (icache_miss_ack) begin
      req_valid_d = 1'b1;
      req_id_d    = icache_miss_idx;
      req_type_d  = L2_REQ_IFETCH;
      req_addr_d  = icache_miss_addr;
    end
  end

  assign resp_hit = l2_response_valid && (l2_response_core == CORE_ID);

  always_comb begin
    resp_valid_d = resp_hit;
    resp_cache_d = resp_cache_q;
    resp_idx_d   = resp_idx_q;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    if (resp_hit) begin
      resp_cache_d = l2_response_cache;
      resp_idx_d   = l2_response_id;
      resp_addr_d  = l2_response_address;
      resp_data_d  = l2_response_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q  <= 1'b0;
      req_id_q     <= '0;
      req_type_q   <= L2_REQ_LOAD;
      req_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_cache_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_id_q     <= req_id_d;
      req_type_q   <= req_type_d;
      req_addr_q   <= req_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_cache_q <= resp_cache_d;
      resp_idx_q   <= resp_idx_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign l2_request_valid   = req_valid_q;
  assign l2_request_core    = CORE_ID;
  assign l2_request_id      = req_id_q;
  assign l2_request_type    = req_type_q;
  assign l2_request_address = req_addr_q;

  assign dcache_response_valid = resp_valid_q && !resp_cache_q;
  assign icache_response_valid = resp_valid_q && resp_cache_q;
  assign response_idx          = resp_idx_q;
  assign fill_address          = resp_addr_q;
  assign fill_data             = resp_data_q;

endmodule

// File: tb/tb_l1_l2_interface.sv
module tb_l1_l2_interface;
  import l1_l2_interface_pkg::*;

  localparam core_id_t CID = 4'd5;

  logic               clk = 1'b0;
  logic               reset;
  logic               dcache_miss_ready, dcache_miss_ack, dcache_miss_synchronized;
  scalar_t            dcache_miss_addr;
  l1_miss_entry_idx_t dcache_miss_idx;
  logic               icache_miss_ready, icache_miss_ack;
  scalar_t            icache_miss_addr;
  l1_miss_entry_idx_t icache_miss_idx;
  logic               l2_request_valid, l2_request_ready;
  core_id_t           l2_request_core;
  l1_miss_entry_idx_t l2_request_id;
  l2_req_type_t       l2_request_type;
  scalar_t            l2_request_address;
  logic               l2_response_valid, l2_response_cache;
  core_id_t           l2_response_core;
  l1_miss_entry_idx_t l2_response_id;
  scalar_t            l2_response_address;
  cache_line_data_t   l2_response_data;
  logic               dcache_response_valid, icache_response_valid;
  l1_miss_entry_idx_t response_idx;
  scalar_t            fill_address;
  cache_line_data_t   fill_data;

  l1_l2_interface #(.CORE_ID(CID)) dut (
    .clk(clk), .reset(reset),
    .dcache_miss_ready(dcache_miss_ready), .dcache_miss_ack(dcache_miss_ack),
    .dcache_miss_addr(dcache_miss_addr), .dcache_miss_idx(dcache_miss_idx),
    .dcache_miss_synchronized(dcache_miss_synchronized),
    .icache_miss_ready(icache_miss_ready), .icache_miss_ack(icache_miss_ack),
    .icache_miss_addr(icache_miss_addr), .icache_miss_idx(icache_miss_idx),
    .l2_request_valid(l2_request_valid), .l2_request_ready(l2_request_ready),
    .l2_request_core(l2_request_core), .l2_request_id(l2_request_id),
    .l2_request_type(l2_request_type), .l2_request_address(l2_request_address),
    .l2_response_valid(l2_response_valid), .l2_response_core(l2_response_core),
    .l2_response_id(l2_response_id), .l2_response_cache(l2_response_cache),
    .l2_response_address(l2_response_address), .l2_response_data(l2_response_data),
    .dcache_response_valid(dcache_response_valid), .icache_response_valid(icache_response_valid),
    .response_idx(response_idx), .fill_address(fill_address), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [1:0]  id;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic         cache;
    logic [1:0]   id;
    logic [31:0]  addr;
    logic [511:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arbitration order, register occupancy and expected
  // response pulses, derived from the ready/ack and response rules.
  bit m_full   = 0;
  bit m_favour_i = 0;
  bit exp_dv   = 0;
  bit exp_iv   = 0;

  always @(negedge clk) begin
    bit free, ed, ei;
    if (reset) begin
      check("rst_dack", dcache_miss_ack, 0);
      check("rst_iack", icache_miss_ack, 0);
      check("rst_req_valid", l2_request_valid, 0);
      check("rst_dresp", dcache_response_valid, 0);
      check("rst_iresp", icache_response_valid, 0);
      check("rst_req_addr", l2_request_address, 0);
      check("rst_req_id", l2_request_id, 0);
      check("rst_req_type", l2_request_type, 0);
      check("rst_resp_idx", response_idx, 0);
      check("rst_fill_addr", fill_address, 0);
      check("rst_fill_data", fill_data, 0);
      m_full = 0; m_favour_i = 0; exp_dv = 0; exp_iv = 0;
      req_q.delete();
      resp_q.delete();
    end else begin
      check("req_valid", l2_request_valid, m_full);
      check("dresp_pulse", dcache_response_valid, exp_dv);
      check("iresp_pulse", icache_response_valid, exp_iv);
      free = !m_full || l2_request_ready;
      ed = 0; ei = 0;
      if (free) begin
        if (dcache_miss_ready && icache_miss_ready) begin
          if (m_favour_i) ei = 1; else ed = 1;
          m_favour_i = !m_favour_i;
        end else if (dcache_miss_ready) ed = 1;
        else if (icache_miss_ready) ei = 1;
      end
      check("dack", dcache_miss_ack, ed);
      check("iack", icache_miss_ack, ei);
      if (ed) req_q.push_back('{dcache_miss_synchronized ? 2'd1 : 2'd0, dcache_miss_idx, dcache_miss_addr});
      if (ei) req_q.push_back('{2'd2, icache_miss_idx, icache_miss_addr});
      if (free) m_full = ed || ei;
      exp_dv = l2_response_valid && (l2_response_core == CID) && !l2_response_cache;
      exp_iv = l2_response_valid && (l2_response_core == CID) && l2_response_cache;
      if (exp_dv || exp_iv)
        resp_q.push_back('{l2_response_cache, l2_response_id, l2_response_address, l2_response_data});
    end
  end

  // Request monitor: every accepted request must be the next one granted.
  always @(negedge clk) begin
    req_t e;
    if (!reset && l2_request_valid && l2_request_ready) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL req_unexpected: got addr %0h expected none", l2_request_address);
      end else begin
        e = req_q.pop_front();
        check("req_type", l2_request_type, e.typ);
        check("req_id", l2_request_id, e.id);
        check("req_addr", l2_request_address, e.addr);
        check("req_core", l2_request_core, CID);
      end
    end
  end

  // Response monitor: each pulse must deliver the next staged response.
  always @(negedge clk) begin
    resp_t e;
    if (!reset && (dcache_response_valid || icache_response_valid)) begin
      if (dcache_response_valid && icache_response_valid) begin
        total++; bad++;
        $display("FAIL resp_both: got both pulses expected one");
      end
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got idx %0h expected none", response_idx);
      end else begin
        e = resp_q.pop_front();
        check("resp_cache", icache_response_valid, e.cache);
        check("resp_idx", response_idx, e.id);
        check("fill_addr", fill_address, e.addr);
        check("fill_data", fill_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dcache_miss_ready = 0; dcache_miss_addr = '0; dcache_miss_idx = '0; dcache_miss_synchronized = 0;
    icache_miss_ready = 0; icache_miss_addr = '0; icache_miss_idx = '0;
    l2_request_ready = 0;
    l2_response_valid = 0; l2_response_core = '0; l2_response_id = '0;
    l2_response_cache = 0; l2_response_address = '0; l2_response_data = '0;
  endtask

  function automatic cache_line_data_t rand_line();
    cache_line_data_t d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    reset = 1;
    idle();
    repeat (3) step();
    reset = 0;
    step();

    // First request: dcache addr 0x1000 idx 2, held two cycles then accepted.
    dcache_miss_ready = 1; dcache_miss_addr = 32'h1000; dcache_miss_idx = 2'd2;
    step();
    idle();
    repeat (2) step();
    l2_request_ready = 1;
    step();
    idle();

    // Both sources ready with L2 always accepting: alternating grants.
    l2_request_ready = 1;
    for (int i = 0; i < 8; i++) begin
      dcache_miss_ready = 1; dcache_miss_addr = 32'h4000 + i * 64; dcache_miss_idx = 2'(i);
      icache_miss_ready = 1; icache_miss_addr = 32'h8000 + i * 64; icache_miss_idx = 2'(i + 1);
      step();
    end
    dcache_miss_ready = 0; icache_miss_ready = 0;
    repeat (2) step();

    // Hold: one grant into the empty register, then 5 cycles stalled.
    l2_request_ready = 0;
    dcache_miss_ready = 1; dcache_miss_addr = 32'hA000; dcache_miss_idx = 2'd1;
    icache_miss_ready = 1; icache_miss_addr = 32'hB000; icache_miss_idx = 2'd3;
    repeat (6) step();
    l2_request_ready = 1;
    step();
    idle();
    l2_request_ready = 1;
    repeat (2) step();

    // Synchronized dcache load.
    dcache_miss_ready = 1; dcache_miss_synchronized = 1;
    dcache_miss_addr = 32'hC040; dcache_miss_idx = 2'd0;
    step();
    idle();
    l2_request_ready = 1;
    repeat (2) step();

    // Response for this core, then the same response for another core.
    l2_response_valid = 1; l2_response_core = CID; l2_response_cache = 1;
    l2_response_id = 2'd3; l2_response_address = 32'h2000; l2_response_data = rand_line();
    step();
    l2_response_core = CID + 4'd1;
    step();
    idle();
    repeat (2) step();

    // Reset with a held request and a staged response.
    dcache_miss_ready = 1; dcache_miss_addr = 32'hD000; dcache_miss_idx = 2'd2;
    step();
    dcache_miss_ready = 0;
    l2_response_valid = 1; l2_response_core = CID; l2_response_cache = 0;
    l2_response_id = 2'd1; l2_response_address = 32'hE000; l2_response_data = rand_line();
    step();
    dcache_miss_ready = 1; icache_miss_ready = 1;
    reset = 1;
    repeat (2) step();
    idle();
    reset = 0;
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      dcache_miss_ready = 1'($urandom_range(0, 1));
      dcache_miss_addr = $urandom & 32'hFFFF_FFC0;
      dcache_miss_idx = 2'($urandom);
      dcache_miss_synchronized = 1'($urandom_range(0, 1));
      icache_miss_ready = 1'($urandom_range(0, 1));
      icache_miss_addr = $urandom & 32'hFFFF_FFC0;
      icache_miss_idx = 2'($urandom);
      l2_request_ready = ($urandom_range(0, 9) < 7);
      l2_response_valid = ($urandom_range(0, 9) < 6);
      l2_response_core = ($urandom_range(0, 3) != 0) ? CID : core_id_t'($urandom);
      l2_response_cache = 1'($urandom_range(0, 1));
      l2_response_id = 2'($urandom);
      l2_response_address = $urandom;
      l2_response_data = rand_line();
      step();
    end

    // Drain and confirm nothing expected was left undelivered.
    idle();
    l2_request_ready = 1;
    repeat (4) step();
    check("req_queue_drained", req_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
